// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues word loads to the memory controller and
// buffers {pc, inst} responses for decode. Optional JAL predecode: define FETCH_JAL_PREDECODE_EN.
`ifndef MEM_NOP
`define MEM_NOP   2'b00
`endif
`ifndef MEM_LOAD
`define MEM_LOAD  2'b01
`endif
`ifndef MEM_STORE
`define MEM_STORE 2'b10
`endif
`ifndef MEM_WORD
`define MEM_WORD  2'b10
`endif

module inst_fetch_queue #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        take_jmp,
    input  logic [31:0] jmp_addr,
    output logic [1:0]  IF_op,
    output logic [1:0]  IF_len,
    output logic [31:0] IF_addr,
    input  logic        IF_rdy,
    input  logic [31:0] IF_out,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_pred,
    input  logic        id_ready
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             discard_q, discard_d;

    logic [31:0] pc_mem_q   [QUEUE_DEPTH];
    logic [31:0] inst_mem_q [QUEUE_DEPTH];

    logic        full;
    logic        pop;
    logic        push;
    logic        push_pred;
    logic [31:0] pc_step;

    assign full     = (count_q == FULL_COUNT);
    assign id_valid = (count_q != '0);

    // Neither a pop nor a push happens on a stalled or redirecting cycle.
    assign pop  = rdy_in && !take_jmp && id_valid && id_ready;
    assign push = rdy_in && !take_jmp && !discard_q && IF_rdy && (!full || pop);

`ifdef FETCH_JAL_PREDECODE_EN
    logic        pred_mem_q [QUEUE_DEPTH];
    logic        is_jal;
    logic [31:0] jal_offset;

    assign is_jal     = (IF_out[6:0] == 7'b1101111);
    assign jal_offset = {{11{IF_out[31]}}, IF_out[31], IF_out[19:12], IF_out[20],
                         IF_out[30:21], 1'b0};
    assign pc_step    = is_jal ? jal_offset : 32'd4;
    assign push_pred  = is_jal;
    assign id_pred    = id_valid && pred_mem_q[head_q];

    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            pred_mem_q[tail_q] <= push_pred;
        end
    end
`else
    assign pc_step   = 32'd4;
    assign push_pred = 1'b0;
    assign id_pred   = 1'b0;
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        discard_d  = discard_q;
        if (rdy_in) begin
            discard_d = 1'b0;
            if (take_jmp) begin
                fetch_pc_d = jmp_addr;
                head_d     = '0;
                tail_d     = '0;
                count_d    = '0;
                discard_d  = 1'b1;
            end else begin
                if (pop) begin
                    head_d = head_q + PTR_W'(1);
                end
                if (push) begin
                    tail_d     = tail_q + PTR_W'(1);
                    fetch_pc_d = fetch_pc_q + pc_step;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            discard_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            discard_q  <= discard_d;
        end
    end

    // Payload storage is not reset; id_* are masked by id_valid instead.
    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            pc_mem_q[tail_q]   <= fetch_pc_q;
            inst_mem_q[tail_q] <= IF_out;
        end
    end

    assign id_pc   = id_valid ? pc_mem_q[head_q]   : 32'h0;
    assign id_inst = id_valid ? inst_mem_q[head_q] : 32'h0;

    assign IF_op   = full ? `MEM_NOP : `MEM_LOAD;
    assign IF_len  = `MEM_WORD;
    assign IF_addr = fetch_pc_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed, scoreboard-based bench for inst_fetch_queue (depth 4, reset PC 0).
`timescale 1ns/1ps
`ifndef MEM_NOP
`define MEM_NOP   2'b00
`endif
`ifndef MEM_LOAD
`define MEM_LOAD  2'b01
`endif
`ifndef MEM_WORD
`define MEM_WORD  2'b10
`endif

module tb_inst_fetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        take_jmp;
    logic [31:0] jmp_addr;
    logic [1:0]  if_op;
    logic [1:0]  if_len;
    logic [31:0] if_addr;
    logic        if_rdy;
    logic [31:0] if_out;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_pred;
    logic        id_ready;

    int checks = 0;
    int errors = 0;

    entry_t      sb[$];
    logic [31:0] m_pc;
    logic        m_discard;

    always #5 clk = ~clk;

    inst_fetch_queue #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .rdy_in   (rdy),
        .take_jmp (take_jmp),
        .jmp_addr (jmp_addr),
        .IF_op    (if_op),
        .IF_len   (if_len),
        .IF_addr  (if_addr),
        .IF_rdy   (if_rdy),
        .IF_out   (if_out),
        .id_valid (id_valid),
        .id_inst  (id_inst),
        .id_pc    (id_pc),
        .id_pred  (id_pred),
        .id_ready (id_ready)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compares DUT outputs with the model, drives one cycle of inputs, updates the model,
    // and returns 1ns after the rising edge.
    task automatic applyStimulus(input logic ifr, input logic [31:0] word, input logic idr,
                                 input logic jmp, input logic [31:0] ja, input logic rdy_v);
        entry_t e;
        logic   pop_m;
        logic   acc_m;
        logic [31:0] step;
        checkOutput("id_valid", {31'b0, id_valid}, {31'b0, (sb.size() != 0)});
        if (sb.size() != 0) begin
            checkOutput("id_pc",   id_pc,   sb[0].pc);
            checkOutput("id_inst", id_inst, sb[0].inst);
            checkOutput("id_pred", {31'b0, id_pred}, {31'b0, sb[0].pred});
        end
        checkOutput("IF_addr", if_addr, m_pc);
        checkOutput("IF_op", {30'b0, if_op}, {30'b0, (sb.size() == 4) ? `MEM_NOP : `MEM_LOAD});
        checkOutput("IF_len", {30'b0, if_len}, {30'b0, `MEM_WORD});

        if_rdy   = ifr;
        if_out   = word;
        id_ready = idr;
        take_jmp = jmp;
        jmp_addr = ja;
        rdy      = rdy_v;

        if (rdy_v) begin
            if (jmp) begin
                sb.delete();
                m_pc      = ja;
                m_discard = 1'b1;
            end else begin
                pop_m = (sb.size() != 0) && idr;
                acc_m = ifr && !m_discard && ((sb.size() < 4) || pop_m);
                if (pop_m) void'(sb.pop_front());
                if (acc_m) begin
                    step   = 32'd4;
                    e.pc   = m_pc;
                    e.inst = word;
                    e.pred = 1'b0;
`ifdef FETCH_JAL_PREDECODE_EN
                    if (word[6:0] == 7'b1101111) begin
                        e.pred = 1'b1;
                        step   = {{11{word[31]}}, word[31], word[19:12], word[20],
                                  word[30:21], 1'b0};
                    end
`endif
                    sb.push_back(e);
                    m_pc = m_pc + step;
                end
                m_discard = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic idr);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, idr, 1'b0, 32'h0, 1'b1);
    endtask

    // Reset is held while a response is arriving, to show reset wins over a fetch.
    task automatic doReset();
        rst = 1'b1; rdy = 1'b1; take_jmp = 1'b0; jmp_addr = 32'h0;
        if_rdy = 1'b1; if_out = 32'hDEAD_0013; id_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0; if_rdy = 1'b0;
        sb.delete();
        m_pc = 32'h0;
        m_discard = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        doReset();
        checkOutput("rst_id_valid", {31'b0, id_valid}, 32'h0);
        checkOutput("rst_id_inst", id_inst, 32'h0);
        checkOutput("rst_id_pc", id_pc, 32'h0);
        checkOutput("rst_id_pred", {31'b0, id_pred}, 32'h0);
        checkOutput("rst_IF_op", {30'b0, if_op}, {30'b0, `MEM_LOAD});
        checkOutput("rst_IF_len", {30'b0, if_len}, {30'b0, `MEM_WORD});
        checkOutput("rst_IF_addr", if_addr, 32'h0);

        // Sequential fetch, one response every 8 cycles.
        applyStimulus(1'b1, 32'hA000_0013, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("seq_addr_A", if_addr, 32'h4);
        checkOutput("seq_pc_A", id_pc, 32'h0);
        checkOutput("seq_inst_A", id_inst, 32'hA000_0013);
        idle(7, 1'b1);
        applyStimulus(1'b1, 32'hB000_0013, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("seq_addr_B", if_addr, 32'h8);
        checkOutput("seq_pc_B", id_pc, 32'h4);
        idle(7, 1'b1);
        applyStimulus(1'b1, 32'hC000_0013, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("seq_addr_C", if_addr, 32'hC);
        checkOutput("seq_inst_C", id_inst, 32'hC000_0013);
        idle(3, 1'b1);

        // Backpressure: fill, drop a fifth word, pop one, refetch at 0x10.
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'h1000_0013 + (i << 12), 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("bp_full_op", {30'b0, if_op}, {30'b0, `MEM_NOP});
        applyStimulus(1'b1, 32'hEEEE_0013, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("bp_drop_addr", if_addr, 32'h10);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("bp_pop_op", {30'b0, if_op}, {30'b0, `MEM_LOAD});
        applyStimulus(1'b1, 32'hF000_0013, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("bp_refetch_addr", if_addr, 32'h14);
        idle(5, 1'b1);

        // Redirect with a same-cycle response and a stale one next cycle.
        applyStimulus(1'b1, 32'h2100_0013, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h2200_0013, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h2300_0013, 1'b1, 1'b1, 32'h100, 1'b1);
        applyStimulus(1'b1, 32'h2400_0013, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("jmp_empty", {31'b0, id_valid}, 32'h0);
        checkOutput("jmp_addr", if_addr, 32'h100);
        applyStimulus(1'b1, 32'h2500_0013, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("jmp_head_pc", id_pc, 32'h100);

        // Stall: nothing moves while rdy_in is low.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 32'h3000_0013, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("stall_addr", if_addr, 32'h104);
        checkOutput("stall_pc", id_pc, 32'h100);
        applyStimulus(1'b1, 32'h3100_0013, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("stall_resume_addr", if_addr, 32'h108);
        idle(3, 1'b1);

        // Wrap-around with push and pop while full.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'h4000_0013 + (i << 12), 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h4F00_0013, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("wrap_full_pushpop", {30'b0, if_op}, {30'b0, `MEM_NOP});
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 32'h5000_0013 + (i << 12), (i % 2 == 0), 1'b0, 32'h0, 1'b1);
        idle(6, 1'b1);

        // JAL at pc 0x20 (offset +8).
        doReset();
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 32'h6000_0013 + (i << 12), 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0080_006F, 1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("jal_head_pc", id_pc, 32'h20);
`ifdef FETCH_JAL_PREDECODE_EN
        checkOutput("jal_addr", if_addr, 32'h28);
        checkOutput("jal_pred", {31'b0, id_pred}, 32'h1);
`else
        checkOutput("jal_addr", if_addr, 32'h24);
        checkOutput("jal_pred", {31'b0, id_pred}, 32'h0);
`endif
        idle(3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction-fetch stage directly upstream of the memory controller's IF port.
- Owns the fetch PC and drives word-fetch requests (IF_op/IF_len/IF_addr).
- Captures each IF_rdy/IF_out response into a small FIFO of {pc, inst} pairs, which presents instructions to decode with a valid/ready handshake.
- Flushes and redirects on take_jmp.

Parameters:
- QUEUE_DEPTH, 4, number of {pc, inst} entries; power of 2, at least 2.
- RESET_PC, 32'h0, fetch PC loaded on reset.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-high
- rdy_in  input  1  global ready; when low, all state holds
- take_jmp  input  1  redirect from execute; same signal the memory controller sees
- jmp_addr  input  32  redirect target, valid when take_jmp=1
- IF_op  output  2  `MEM_LOAD when queue has space, else `MEM_NOP
- IF_len  output  2  constant `MEM_WORD
- IF_addr  output  32  current fetch PC
- IF_rdy  input  1  one-cycle response pulse from memory controller
- IF_out  input  32  fetched word, valid with IF_rdy
- id_valid  output  1  queue head valid
- id_inst  output  32  head instruction
- id_pc  output  32  head PC
- id_pred  output  1  head was predicted taken (see Optional Feature)
- id_ready  input  1  decode accepts head this cycle

Behaviour:
- Clock and reset: single clock, clk_in. rst_in is synchronous, active-high and wins over everything, including a reset mid-fetch.
- Reset values: fetch_pc=RESET_PC; queue empty (head=tail=0, count=0); discard=0. Resulting outputs: id_valid=0, id_inst=0, id_pc=0, id_pred=0, IF_op=`MEM_LOAD, IF_len=`MEM_WORD, IF_addr=RESET_PC.
- Output timing: IF_addr, IF_op, IF_len and id_* are combinational from registers only, with no combinational path from inputs.
- rdy_in=0: no register changes; IF_rdy and id_ready are ignored that cycle.
- With rdy_in=1, priority is reset > take_jmp > normal.
- take_jmp=1:
  - Flush the queue (count=0, pointers to 0) and set fetch_pc=jmp_addr.
  - Set discard=1.
  - Any IF_rdy in the same cycle is dropped, and a pop does not occur.
- discard: any IF_rdy in the cycle after a redirect is dropped, because the controller may hold a stale IF_rdy for one cycle. discard clears after one rdy_in=1 cycle.
- Accept: IF_rdy=1 with no take_jmp, discard=0, and space available (count<QUEUE_DEPTH, or a pop in the same cycle).
  - Push {fetch_pc, IF_out, pred} at tail; tail wraps modulo QUEUE_DEPTH.
  - fetch_pc += 4, mod 2^32 wrap.
- IF_rdy while full with no pop: the word is dropped and fetch_pc is unchanged, so the same address is refetched.
- IF_addr is held stable between accepted responses, so a response always belongs to the current fetch_pc.
- Pop: id_valid && id_ready. Head advances modulo depth.
- Simultaneous push and pop: count unchanged; the data remains correct when the queue is full.
- Push to an empty queue: the entry is visible on id_* in the next cycle (1-cycle latency from IF_rdy to id_valid).
- id_valid=(count!=0). id_* hold their values while id_valid=1 and id_ready=0.
- IF_op=`MEM_NOP exactly when count==QUEUE_DEPTH.

Optional Feature:
- Macro: FETCH_JAL_PREDECODE_EN.
- Defined:
  - On accept, if IF_out[6:0]==7'b1101111 (JAL), set fetch_pc = fetch_pc + sext({IF_out[31],IF_out[19:12],IF_out[20],IF_out[30:21],1'b0}) instead of +4.
  - The stored pred bit is 1; id_pred reflects it so execute can suppress the redundant take_jmp.
  - No discard is needed, because the controller samples IF_addr only after its two stall cycles.
- Undefined: fetch_pc always += 4, pred bits are absent, and id_pred is tied to 0.

Test Plan:
- Sequential fetch: reset, then IF_rdy pulses with words A,B,C every 8 cycles, id_ready=1.
  - IF_addr steps 0→4→8→C.
  - id_pc/id_inst = 0/A, 4/B, 8/C, each one cycle after its IF_rdy.
- Backpressure: id_ready=0 with 4 responses.
  - count=4, IF_op=`MEM_NOP.
  - A 5th IF_rdy is dropped and IF_addr stays 0x10.
  - After one pop, a response at 0x10 is accepted.
- Redirect: take_jmp=1, jmp_addr=0x100 in the same cycle as IF_rdy, then a stale IF_rdy on the next cycle.
  - Both words are dropped and the queue is empty.
  - IF_addr=0x100; the next IF_rdy is pushed with id_pc=0x100.
- Stall: rdy_in=0 for 5 cycles while IF_rdy=1 and id_ready=1.
  - No push, pop, or PC change.
  - Normal behaviour resumes when rdy_in=1.
- Wrap-around: run 10 push/pop pairs with id_ready toggling.
  - Inst order and PCs are preserved across pointer wrap.
  - A push and pop in the same cycle while full keeps count=4.
- JAL (macro on): IF_out=32'h0080006F at pc 0x20.
  - Next IF_addr=0x28, id_pred=1.
  - Macro off: IF_addr=0x24, id_pred=0.
